mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 236 +++++++++++++++++++++++
 tb/tb_mc_control.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset control unit: fetch/decode/execute FSM with memory
// wait timeout, sticky trap state and a retired-instruction counter.
module mc_control #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Fun,
  input  logic             equal,
  input  logic             sign,
  input  logic             mem_ready,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RegWr,
  output logic             RegDst,
  output logic             ExtOp,
  output logic             ALUSrc,
  output logic             MemRd,
  output logic             MemWr,
  output logic             MemtoReg,
  output logic             nPC_sel,
  output logic [2:0]       ALUctr,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB       = 4'd7,
    S_BRANCH   = 4'd8,
    S_TRAP     = 4'd9
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_ADDU = 3'd4;
  localparam logic [2:0] ALU_SLL  = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_SLTU = 3'd7;

  // Wide enough to hold MEM_TIMEOUT; a zero timeout still gets a 1-bit counter.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire, waiting, timeout, taken;
  logic               fun_ok;
  logic [2:0]         fun_alu;

  always_comb begin
    fun_ok  = 1'b1;
    fun_alu = ALU_ADD;
    case (Fun)
      6'h20:   fun_alu = ALU_ADD;
      6'h21:   fun_alu = ALU_ADDU;
      6'h22:   fun_alu = ALU_SUB;
      6'h23:   fun_alu = ALU_SUB;
      6'h24:   fun_alu = ALU_AND;
      6'h25:   fun_alu = ALU_OR;
      6'h00:   fun_alu = ALU_SLL;
      6'h2A:   fun_alu = ALU_SLT;
      6'h2B:   fun_alu = ALU_SLTU;
      default: fun_ok  = 1'b0;
    endcase
  end

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path through this block can leave a value unassigned (no latches).
  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    ExtOp    = 1'b0;
    ALUSrc   = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    MemtoReg = 1'b0;
    nPC_sel  = 1'b0;
    ALUctr   = ALU_AND;
    illegal  = 1'b0;
    retire   = 1'b0;
    state_d  = state_q;

    waiting  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    wait_inc = wait_q + WAIT_W'(1);
    // The timeout fires in the MEM_TIMEOUT-th consecutive cycle without mem_ready.
    timeout  = (MEM_TIMEOUT != 0) && waiting && !mem_ready &&
               (wait_inc == WAIT_W'(MEM_TIMEOUT));
    taken    = ((Op == OP_BEQ) && equal) || ((Op == OP_BNE) && !equal) ||
               ((Op == OP_BGTZ) && !equal && !sign);

    case (state_q)
      S_FETCH: begin
        MemRd = 1'b1;
        if (mem_ready) begin
          IRWr    = 1'b1;
          PCWr    = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        case (Op)
          OP_RTYPE: if (fun_ok) state_d = S_EXEC_R;
                    else begin illegal = 1'b1; state_d = S_FETCH; end
          OP_ADDI:                 state_d = S_EXEC_I;
          OP_LW, OP_SW:            state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE, OP_BGTZ: state_d = S_BRANCH;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        ALUctr  = fun_alu;
        RegDst  = 1'b1;
        RegWr   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrc  = 1'b1;
        ExtOp   = 1'b1;
        ALUctr  = ALU_ADD;
        RegWr   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrc  = 1'b1;
        ExtOp   = 1'b1;
        ALUctr  = ALU_ADD;
        state_d = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRd  = 1'b1;
        ALUSrc = 1'b1;
        ExtOp  = 1'b1;
        ALUctr = ALU_ADD;
        if (mem_ready)    state_d = S_WB;
        else if (timeout) state_d = S_TRAP;
      end
      S_WB: begin
        MemtoReg = 1'b1;
        RegWr    = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          MemWr   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
        end else begin
          MemWr = 1'b1;
        end
      end
      S_BRANCH: begin
        ALUctr  = ALU_SUB;
        PCWr    = taken;
        nPC_sel = taken;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Reset silences every control output in the same cycle, not just at the edge.
    if (reset) begin
      PCWr     = 1'b0;
      IRWr     = 1'b0;
      RegWr    = 1'b0;
      RegDst   = 1'b0;
      ExtOp    = 1'b0;
      ALUSrc   = 1'b0;
      MemRd    = 1'b0;
      MemWr    = 1'b0;
      MemtoReg = 1'b0;
      nPC_sel  = 1'b0;
      ALUctr   = ALU_AND;
      illegal  = 1'b0;
    end

    if (state_d != state_q)          wait_d = '0;
    else if (waiting && !mem_ready)  wait_d = wait_inc;
    else                             wait_d = wait_q;

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous,
  // so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_TRAP);
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: each test queues per-cycle stimulus and the
// expected observation, then replays the stimulus and compares cycle by cycle.
module tb_mc_control;

  localparam int CNT_W       = 2;
  localparam int MEM_TIMEOUT = 4;

  localparam logic [9:0] C_PCW    = 10'h200;
  localparam logic [9:0] C_IRW    = 10'h100;
  localparam logic [9:0] C_REGW   = 10'h080;
  localparam logic [9:0] C_REGDST = 10'h040;
  localparam logic [9:0] C_EXT    = 10'h020;
  localparam logic [9:0] C_ALUSRC = 10'h010;
  localparam logic [9:0] C_MEMRD  = 10'h008;
  localparam logic [9:0] C_MEMWR  = 10'h004;
  localparam logic [9:0] C_M2R    = 10'h002;
  localparam logic [9:0] C_NPC    = 10'h001;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fun;
    logic       eq;
    logic       sg;
    logic       rdy;
    logic       rst;
  } stim_t;

  typedef struct packed {
    logic [3:0]       st;
    logic [9:0]       ctrl;
    logic [2:0]       alu;
    logic             ill;
    logic             halt;
    logic [CNT_W-1:0] ret;
  } snap_t;

  logic clk = 1'b0;
  logic reset, equal, sign, mem_ready;
  logic [5:0] Op, Fun;
  logic PCWr, IRWr, RegWr, RegDst, ExtOp, ALUSrc, MemRd, MemWr, MemtoReg, nPC_sel;
  logic [2:0] ALUctr;
  logic [3:0] state;
  logic illegal, halted;
  logic [CNT_W-1:0] retired;

  stim_t            stim_q[$];
  snap_t            exp_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] ret_m = '0;

  always #5 clk = ~clk;

  mc_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Fun(Fun), .equal(equal), .sign(sign),
    .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .RegDst(RegDst),
    .ExtOp(ExtOp), .ALUSrc(ALUSrc), .MemRd(MemRd), .MemWr(MemWr), .MemtoReg(MemtoReg),
    .nPC_sel(nPC_sel), .ALUctr(ALUctr), .state(state), .illegal(illegal),
    .halted(halted), .retired(retired)
  );

  function automatic stim_t sti(input logic [5:0] op, input logic [5:0] fun,
                                input logic eq, input logic sg,
                                input logic rdy, input logic rst);
    sti = {op, fun, eq, sg, rdy, rst};
  endfunction

  function automatic snap_t mk(input logic [3:0] st, input logic [9:0] c,
                               input logic [2:0] a, input logic ill, input logic h);
    mk = {st, c, a, ill, h, ret_m};
  endfunction

  task automatic push(input stim_t s, input snap_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cycle(input stim_t s, output snap_t obs);
    Op = s.op; Fun = s.fun; equal = s.eq; sign = s.sg; mem_ready = s.rdy; reset = s.rst;
    @(negedge clk);
    obs = {state, {PCWr, IRWr, RegWr, RegDst, ExtOp, ALUSrc, MemRd, MemWr, MemtoReg, nPC_sel},
           ALUctr, illegal, halted, retired};
    @(posedge clk);
    #1;
  endtask

  // Reset cycle: outputs silent even with mem_ready high in FETCH.
  task automatic test_reset();
    snap_t obs, exp;
    stim_t s;
    int idx = 0;
    push(sti(6'h00, 6'h20, 0, 0, 1, 1), mk(4'd0, 10'h0, 3'd0, 0, 0));
    push(sti(6'h00, 6'h20, 0, 0, 0, 0), mk(4'd0, C_MEMRD, 3'd0, 0, 0));
    push(sti(6'h00, 6'h20, 0, 0, 0, 1), mk(4'd0, 10'h0, 3'd0, 0, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); cycle(s, obs); exp = exp_q.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL reset cycle %0d: got %p want %p", idx, obs, exp);
      end
      idx++;
    end
  endtask

  task automatic test_rtype();
    snap_t obs, exp;
    stim_t s;
    int idx = 0;
    logic [5:0] funs [9];
    logic [2:0] alus [9];
    funs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00, 6'h2A, 6'h2B};
    alus = '{3'd2,  3'd4,  3'd6,  3'd6,  3'd0,  3'd1,  3'd5,  3'd3,  3'd7};
    for (int i = 0; i < 9; i++) begin
      push(sti(6'h00, funs[i], 0, 0, 1, 0), mk(4'd0, C_PCW | C_IRW | C_MEMRD, 3'd0, 0, 0));
      push(sti(6'h00, funs[i], 0, 0, 0, 0), mk(4'd1, 10'h0, 3'd0, 0, 0));
      push(sti(6'h00, funs[i], 0, 0, 1, 0), mk(4'd2, C_REGW | C_REGDST, alus[i], 0, 0));
      ret_m++;
    end
    push(sti(6'h00, 6'h20, 0, 0, 0, 0), mk(4'd0, C_MEMRD, 3'd0, 0, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); cycle(s, obs); exp = exp_q.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL rtype cycle %0d: got %p want %p", idx, obs, exp);
      end
      idx++;
    end
  endtask

  // lw with three stalled cycles in MEM_RD; mem_ready in DECODE/MEM_ADDR is ignored.
  task automatic test_lw();
    snap_t obs, exp;
    stim_t s;
    int idx = 0;
    push(sti(6'h23, 6'h00, 0, 0, 1, 0), mk(4'd0, C_PCW | C_IRW | C_MEMRD, 3'd0, 0, 0));
    push(sti(6'h23, 6'h00, 0, 0, 1, 0), mk(4'd1, 10'h0, 3'd0, 0, 0));
    push(sti(6'h23, 6'h00, 0, 0, 1, 0), mk(4'd4, C_EXT | C_ALUSRC, 3'd2, 0, 0));
    for (int i = 0; i < 3; i++)
      push(sti(6'h23, 6'h00, 0, 0, 0, 0), mk(4'd5, C_MEMRD | C_EXT | C_ALUSRC, 3'd2, 0, 0));
    push(sti(6'h23, 6'h00, 0, 0, 1, 0), mk(4'd5, C_MEMRD | C_EXT | C_ALUSRC, 3'd2, 0, 0));
    push(sti(6'h23, 6'h00, 0, 0, 1, 0), mk(4'd7, C_M2R | C_REGW, 3'd0, 0, 0));
    ret_m++;
    push(sti(6'h23, 6'h00, 0, 0, 0, 0), mk(4'd0, C_MEMRD, 3'd0, 0, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); cycle(s, obs); exp = exp_q.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL lw cycle %0d: got %p want %p", idx, obs, exp);
      end
      idx++;
    end
  endtask

  task automatic test_sw();
    snap_t obs, exp;
    stim_t s;
    int idx = 0;
    push(sti(6'h2B, 6'h00, 0, 0, 1, 0), mk(4'd0, C_PCW | C_IRW | C_MEMRD, 3'd0, 0, 0));
    push(sti(6'h2B, 6'h00, 0, 0, 0, 0), mk(4'd1, 10'h0, 3'd0, 0, 0));
    push(sti(6'h2B, 6'h00, 0, 0, 0, 0), mk(4'd4, C_EXT | C_ALUSRC, 3'd2, 0, 0));
    push(sti(6'h2B, 6'h00, 0, 0, 0, 0), mk(4'd6, C_MEMWR, 3'd0, 0, 0));
    push(sti(6'h2B, 6'h00, 0, 0, 0, 0), mk(4'd6, C_MEMWR, 3'd0, 0, 0));
    push(sti(6'h2B, 6'h00, 0, 0, 1, 0), mk(4'd6, C_MEMWR, 3'd0, 0, 0));
    ret_m++;
    push(sti(6'h2B, 6'h00, 0, 0, 0, 0), mk(4'd0, C_MEMRD, 3'd0, 0, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); cycle(s, obs); exp = exp_q.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL sw cycle %0d: got %p want %p", idx, obs, exp);
      end
      idx++;
    end
  endtask

  task automatic test_branch();
    snap_t obs, exp;
    stim_t s;
    int idx = 0;
    logic [5:0] ops [7];
    logic eqs [7];
    logic sgs [7];
    logic tk  [7];
    ops = '{6'h07, 6'h07, 6'h07, 6'h04, 6'h04, 6'h05, 6'h05};
    eqs = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
    sgs = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
    tk  = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    for (int i = 0; i < 7; i++) begin
      push(sti(ops[i], 6'h00, eqs[i], sgs[i], 1, 0), mk(4'd0, C_PCW | C_IRW | C_MEMRD, 3'd0, 0, 0));
      push(sti(ops[i], 6'h00, eqs[i], sgs[i], 0, 0), mk(4'd1, 10'h0, 3'd0, 0, 0));
      push(sti(ops[i], 6'h00, eqs[i], sgs[i], 1, 0), mk(4'd8, tk[i] ? (C_PCW | C_NPC) : 10'h0, 3'd6, 0, 0));
      ret_m++;
    end
    push(sti(6'h00, 6'h00, 0, 0, 0, 0), mk(4'd0, C_MEMRD, 3'd0, 0, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); cycle(s, obs); exp = exp_q.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL branch cycle %0d: got %p want %p", idx, obs, exp);
      end
      idx++;
    end
  endtask

  task automatic test_illegal();
    snap_t obs, exp;
    stim_t s;
    int idx = 0;
    logic [5:0] ops [2];
    ops = '{6'h3F, 6'h02};
    for (int i = 0; i < 2; i++) begin
      push(sti(ops[i], 6'h00, 0, 0, 1, 0), mk(4'd0, C_PCW | C_IRW | C_MEMRD, 3'd0, 0, 0));
      push(sti(ops[i], 6'h00, 0, 0, 1, 0), mk(4'd1, 10'h0, 3'd0, 1, 0));
      push(sti(ops[i], 6'h00, 0, 0, 0, 0), mk(4'd0, C_MEMRD, 3'd0, 0, 0));
    end
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); cycle(s, obs); exp = exp_q.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL illegal cycle %0d: got %p want %p", idx, obs, exp);
      end
      idx++;
    end
  endtask

  // Four back-to-back addi retirements on a 2-bit counter: 1,2,3,0.
  task automatic test_back_to_back();
    snap_t obs, exp;
    stim_t s;
    int idx = 0;
    push(sti(6'h08, 6'h00, 0, 0, 0, 1), mk(4'd0, 10'h0, 3'd0, 0, 0));
    ret_m = '0;
    for (int i = 0; i < 4; i++) begin
      push(sti(6'h08, 6'h00, 0, 0, 1, 0), mk(4'd0, C_PCW | C_IRW | C_MEMRD, 3'd0, 0, 0));
      push(sti(6'h08, 6'h00, 0, 0, 0, 0), mk(4'd1, 10'h0, 3'd0, 0, 0));
      push(sti(6'h08, 6'h00, 0, 0, 0, 0), mk(4'd3, C_REGW | C_EXT | C_ALUSRC, 3'd2, 0, 0));
      ret_m++;
    end
    push(sti(6'h08, 6'h00, 0, 0, 0, 0), mk(4'd0, C_MEMRD, 3'd0, 0, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); cycle(s, obs); exp = exp_q.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL back_to_back cycle %0d: got %p want %p", idx, obs, exp);
      end
      idx++;
    end
  endtask

  // Ready on the last allowed wait cycle proceeds; four misses traps until reset.
  task automatic test_fetch_timeout();
    snap_t obs, exp;
    stim_t s;
    int idx = 0;
    push(sti(6'h3F, 6'h00, 0, 0, 0, 1), mk(4'd0, 10'h0, 3'd0, 0, 0));
    for (int i = 0; i < 3; i++)
      push(sti(6'h3F, 6'h00, 0, 0, 0, 0), mk(4'd0, C_MEMRD, 3'd0, 0, 0));
    push(sti(6'h3F, 6'h00, 0, 0, 1, 0), mk(4'd0, C_PCW | C_IRW | C_MEMRD, 3'd0, 0, 0));
    push(sti(6'h3F, 6'h00, 0, 0, 0, 0), mk(4'd1, 10'h0, 3'd0, 1, 0));
    for (int i = 0; i < 4; i++)
      push(sti(6'h3F, 6'h00, 0, 0, 0, 0), mk(4'd0, C_MEMRD, 3'd0, 0, 0));
    push(sti(6'h00, 6'h20, 0, 0, 1, 0), mk(4'd9, 10'h0, 3'd0, 0, 1));
    push(sti(6'h23, 6'h00, 1, 1, 1, 0), mk(4'd9, 10'h0, 3'd0, 0, 1));
    push(sti(6'h3F, 6'h00, 0, 0, 0, 0), mk(4'd9, 10'h0, 3'd0, 0, 1));
    push(sti(6'h00, 6'h20, 0, 0, 1, 1), mk(4'd9, 10'h0, 3'd0, 0, 1));
    ret_m = '0;
    push(sti(6'h00, 6'h20, 0, 0, 0, 0), mk(4'd0, C_MEMRD, 3'd0, 0, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); cycle(s, obs); exp = exp_q.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL fetch_timeout cycle %0d: got %p want %p", idx, obs, exp);
      end
      idx++;
    end
  endtask

  // Store that never completes: MemWr dropped in the timeout cycle, then TRAP.
  task automatic test_store_timeout();
    snap_t obs, exp;
    stim_t s;
    int idx = 0;
    push(sti(6'h2B, 6'h00, 0, 0, 1, 0), mk(4'd0, C_PCW | C_IRW | C_MEMRD, 3'd0, 0, 0));
    push(sti(6'h2B, 6'h00, 0, 0, 0, 0), mk(4'd1, 10'h0, 3'd0, 0, 0));
    push(sti(6'h2B, 6'h00, 0, 0, 0, 0), mk(4'd4, C_EXT | C_ALUSRC, 3'd2, 0, 0));
    for (int i = 0; i < 3; i++)
      push(sti(6'h2B, 6'h00, 0, 0, 0, 0), mk(4'd6, C_MEMWR, 3'd0, 0, 0));
    push(sti(6'h2B, 6'h00, 0, 0, 0, 0), mk(4'd6, 10'h0, 3'd0, 0, 0));
    push(sti(6'h2B, 6'h00, 0, 0, 1, 0), mk(4'd9, 10'h0, 3'd0, 0, 1));
    push(sti(6'h2B, 6'h00, 0, 0, 0, 1), mk(4'd9, 10'h0, 3'd0, 0, 1));
    ret_m = '0;
    push(sti(6'h2B, 6'h00, 0, 0, 0, 0), mk(4'd0, C_MEMRD, 3'd0, 0, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); cycle(s, obs); exp = exp_q.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL store_timeout cycle %0d: got %p want %p", idx, obs, exp);
      end
      idx++;
    end
  endtask

  // Reset in the middle of a stalled load read abandons it and clears the count.
  task automatic test_reset_midaccess();
    snap_t obs, exp;
    stim_t s;
    int idx = 0;
    push(sti(6'h08, 6'h00, 0, 0, 1, 0), mk(4'd0, C_PCW | C_IRW | C_MEMRD, 3'd0, 0, 0));
    push(sti(6'h08, 6'h00, 0, 0, 0, 0), mk(4'd1, 10'h0, 3'd0, 0, 0));
    push(sti(6'h08, 6'h00, 0, 0, 0, 0), mk(4'd3, C_REGW | C_EXT | C_ALUSRC, 3'd2, 0, 0));
    ret_m++;
    push(sti(6'h23, 6'h00, 0, 0, 1, 0), mk(4'd0, C_PCW | C_IRW | C_MEMRD, 3'd0, 0, 0));
    push(sti(6'h23, 6'h00, 0, 0, 0, 0), mk(4'd1, 10'h0, 3'd0, 0, 0));
    push(sti(6'h23, 6'h00, 0, 0, 0, 0), mk(4'd4, C_EXT | C_ALUSRC, 3'd2, 0, 0));
    push(sti(6'h23, 6'h00, 0, 0, 0, 0), mk(4'd5, C_MEMRD | C_EXT | C_ALUSRC, 3'd2, 0, 0));
    push(sti(6'h23, 6'h00, 0, 0, 1, 1), mk(4'd5, 10'h0, 3'd0, 0, 0));
    ret_m = '0;
    push(sti(6'h23, 6'h00, 0, 0, 0, 0), mk(4'd0, C_MEMRD, 3'd0, 0, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); cycle(s, obs); exp = exp_q.pop_front(); n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL reset_midaccess cycle %0d: got %p want %p", idx, obs, exp);
      end
      idx++;
    end
  endtask

  initial begin
    snap_t junk;
    cycle(sti(6'h00, 6'h00, 0, 0, 0, 1), junk);
    cycle(sti(6'h00, 6'h00, 0, 0, 0, 1), junk);
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_fetch_timeout();
    test_store_timeout();
    test_reset_midaccess();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
